// File: rtl/execute_muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// The result struct is the fixed 32-bit form the execute stage hands to write_hilo.
package execute_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULU = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIVU = 2'd2,
        MD_DIV  = 2'd3
    } muldiv_op_t;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MUL_RUN,
        MD_DIV_RUN,
        MD_FIX,
        MD_DONE
    } muldiv_stat_t;

    localparam int MD_HILO_W = 32;

    typedef struct packed {
        logic [MD_HILO_W-1:0] hi;
        logic [MD_HILO_W-1:0] lo;
    } muldiv_result_t;

    function automatic logic md_is_signed(input muldiv_op_t op);
        return (op == MD_MUL) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/execute_muldiv_step.sv
// One combinational iteration of the shared datapath: a MUL_STEP-bit shift-add
// multiply step and a single restoring radix-2 divide step.
module execute_muldiv_step #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_mul_hi,
    output logic [WIDTH-1:0] o_mul_lo,
    output logic [WIDTH-1:0] o_div_hi,
    output logic [WIDTH-1:0] o_div_lo
);

    logic [WIDTH+MUL_STEP-1:0]   w_pp;
    logic [WIDTH+MUL_STEP-1:0]   w_sum;
    logic [2*WIDTH+MUL_STEP-1:0] w_cat;
    logic [WIDTH:0]              w_trial;
    logic [WIDTH:0]              w_diff;

    // Low MUL_STEP multiplier bits select shifted copies of the multiplicand.
    always_comb begin
        w_pp = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (i_lo[k])
                w_pp = w_pp + ({{MUL_STEP{1'b0}}, i_opnd} << k);
        end
    end

    assign w_sum = {{MUL_STEP{1'b0}}, i_hi} + w_pp;
    assign w_cat = {w_sum, i_lo};
    assign {o_mul_hi, o_mul_lo} = w_cat[2*WIDTH+MUL_STEP-1:MUL_STEP];

    // Partial remainder is WIDTH+1 bits wide so the trial subtract never wraps.
    assign w_trial = {i_hi, i_lo[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, i_opnd};

    always_comb begin
        if (!w_diff[WIDTH]) begin
            o_div_hi = w_diff[WIDTH-1:0];
            o_div_lo = {i_lo[WIDTH-2:0], 1'b1};
        end else begin
            o_div_hi = w_trial[WIDTH-1:0];
            o_div_lo = {i_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage: operands are reduced to
// magnitudes on accept, iterated unsigned, then sign-corrected in FIX.
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_CYC = CW'(WIDTH / MUL_STEP);
    localparam logic [CW-1:0] DIV_CYC = CW'(WIDTH);

    muldiv_stat_t    r_state, w_next;
    muldiv_op_t      r_op;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
    logic            r_qsign, r_rsign;

    muldiv_op_t      w_op;
    logic            w_signed, w_is_div, w_dz, w_accept, w_fix_div;
    logic            w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_op      = muldiv_op_t'(op);
    assign w_signed  = md_is_signed(w_op);
    assign w_is_div  = (w_op == MD_DIVU) || (w_op == MD_DIV);
    assign w_dz      = w_is_div && (b == '0);
    assign w_accept  = in_valid && (r_state == MD_IDLE) && !flush;
    assign w_a_neg   = w_signed && a[WIDTH-1];
    assign w_b_neg   = w_signed && b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -a : a;
    assign w_b_mag   = w_b_neg ? -b : b;
    assign w_fix_div = (r_op == MD_DIVU) || (r_op == MD_DIV);
    assign w_prod_neg = -{r_hi, r_lo};

    execute_muldiv_step #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_step (
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_mul_hi (w_mul_hi),
        .o_mul_lo (w_mul_lo),
        .o_div_hi (w_div_hi),
        .o_div_lo (w_div_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= MD_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: begin
                if (w_accept)
                    w_next = w_dz ? MD_FIX : (w_is_div ? MD_DIV_RUN : MD_MUL_RUN);
            end
            MD_MUL_RUN, MD_DIV_RUN: begin
                if (r_cnt == CW'(1))
                    w_next = MD_FIX;
            end
            MD_FIX:  w_next = MD_DONE;
            MD_DONE: begin
                if (out_ready)
                    w_next = MD_IDLE;
            end
            default: w_next = MD_IDLE;
        endcase
        if (flush)
            w_next = MD_IDLE;
    end

    // A flushed operation simply freezes the datapath; hi/lo are don't-care until the next result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= MD_MULU;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_qsign <= w_signed && !w_dz && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_rsign <= w_signed && !w_dz && a[WIDTH-1];
                        if (w_dz) begin
                            r_hi <= a;
                            r_lo <= '1;
                        end else if (w_is_div) begin
                            r_hi   <= '0;
                            r_lo   <= w_a_mag;
                            r_opnd <= w_b_mag;
                            r_cnt  <= DIV_CYC;
                        end else begin
                            r_hi   <= '0;
                            r_lo   <= w_b_mag;
                            r_opnd <= w_a_mag;
                            r_cnt  <= MUL_CYC;
                        end
                    end
                end
                MD_MUL_RUN: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt - 1'b1;
                end
                MD_DIV_RUN: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt - 1'b1;
                end
                MD_FIX: begin
                    if (w_fix_div) begin
                        if (r_qsign) r_lo <= -r_lo;
                        if (r_rsign) r_hi <= -r_hi;
                    end else if (r_qsign) begin
                        {r_hi, r_lo} <= w_prod_neg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == MD_IDLE);
    assign busy      = (r_state != MD_IDLE);
    assign out_valid = (r_state == MD_DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Bench for execute_muldiv_unit: fixed vectors and corner sequences at 32/2,
// plus randomized ops on three 8-bit instances (MUL_STEP 1/2/4) against a reference model.
module tb_execute_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_busy;
    logic [1:0]  f_op;
    logic [31:0] f_a, f_b, f_hi, f_lo;

    logic        e_in_valid, e_out_ready, e_flush;
    logic [1:0]  e_op;
    logic [7:0]  e_a, e_b;
    logic [2:0]  e_in_ready, e_out_valid, e_busy;
    logic [7:0]  e_hi [3];
    logic [7:0]  e_lo [3];

    int n_pass = 0;
    int n_chk  = 0;

    execute_muldiv_unit #(.WIDTH(32), .MUL_STEP(2)) u32 (
        .clk(clk), .reset(rst), .flush(f_flush), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .op(f_op), .a(f_a), .b(f_b), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .hi(f_hi), .lo(f_lo), .busy(f_busy));

    execute_muldiv_unit #(.WIDTH(8), .MUL_STEP(1)) u8_1 (
        .clk(clk), .reset(rst), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready[0]),
        .op(e_op), .a(e_a), .b(e_b), .out_valid(e_out_valid[0]), .out_ready(e_out_ready),
        .hi(e_hi[0]), .lo(e_lo[0]), .busy(e_busy[0]));

    execute_muldiv_unit #(.WIDTH(8), .MUL_STEP(2)) u8_2 (
        .clk(clk), .reset(rst), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready[1]),
        .op(e_op), .a(e_a), .b(e_b), .out_valid(e_out_valid[1]), .out_ready(e_out_ready),
        .hi(e_hi[1]), .lo(e_lo[1]), .busy(e_busy[1]));

    execute_muldiv_unit #(.WIDTH(8), .MUL_STEP(4)) u8_4 (
        .clk(clk), .reset(rst), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready[2]),
        .op(e_op), .a(e_a), .b(e_b), .out_valid(e_out_valid[2]), .out_ready(e_out_ready),
        .hi(e_hi[2]), .lo(e_lo[2]), .busy(e_busy[2]));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural reference: plain integer arithmetic on sign-extended values.
    task automatic refm(input int w, input logic [1:0] op, input longint a, input longint b,
                        output longint rhi, output longint rlo);
        longint mask, sa, sb, p;
        mask = (longint'(1) <<< w) - 1;
        sa = ((a >>> (w-1)) & 1) != 0 ? a - (longint'(1) <<< w) : a;
        sb = ((b >>> (w-1)) & 1) != 0 ? b - (longint'(1) <<< w) : b;
        rhi = 0;
        rlo = 0;
        case (op)
            2'd0: begin
                p = a * b;
                rhi = (p >> w) & mask;
                rlo = p & mask;
            end
            2'd1: begin
                p = sa * sb;
                rhi = (p >> w) & mask;
                rlo = p & mask;
            end
            2'd2: begin
                if (b == 0) begin rhi = a; rlo = mask; end
                else begin rhi = a % b; rlo = a / b; end
            end
            default: begin
                if (b == 0) begin rhi = a; rlo = mask; end
                else begin rhi = (sa % sb) & mask; rlo = (sa / sb) & mask; end
            end
        endcase
    endtask

    function automatic int lat_exp(input int w, input int ms, input logic [1:0] op, input longint b);
        if (op[1]) return (b == 0) ? 2 : w + 2;
        return w / ms + 2;
    endfunction

    // Issue one op on the 32-bit unit; returns at the first out_valid cycle with out_ready low.
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
        f_op = op; f_a = a; f_b = b; f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        lat = 1;
        while (!f_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!f_out_valid) lat = -1;
        hi = f_hi;
        lo = f_lo;
    endtask

    task automatic release32();
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_out_ready = 1'b0;
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int lat [3];
        logic [7:0] ch [3];
        logic [7:0] cl [3];
        int cyc;
        longint rh, rl;
        for (int i = 0; i < 3; i++) begin lat[i] = -1; ch[i] = '0; cl[i] = '0; end
        e_op = op; e_a = a; e_b = b; e_in_valid = 1'b1;
        @(posedge clk); #1;
        e_in_valid = 1'b0;
        cyc = 1;
        while (cyc < 100 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0)) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && e_out_valid[i]) begin
                    lat[i] = cyc; ch[i] = e_hi[i]; cl[i] = e_lo[i];
                end
            end
        end
        refm(8, op, longint'(a), longint'(b), rh, rl);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w8s%0d_op%0d_%02h_%02h_lat", 1 << i, op, a, b), longint'(lat[i]),
                longint'(lat_exp(8, 1 << i, op, longint'(b))));
            chk($sformatf("w8s%0d_op%0d_%02h_%02h_hi", 1 << i, op, a, b), longint'(ch[i]), rh);
            chk($sformatf("w8s%0d_op%0d_%02h_%02h_lo", 1 << i, op, a, b), longint'(cl[i]), rl);
        end
        e_out_ready = 1'b1;
        @(posedge clk); #1;
        e_out_ready = 1'b0;
    endtask

    vec_t vt [9];

    initial begin
        logic [31:0] h, l, h0, l0, ra, rb;
        logic [1:0]  rop;
        longint      rh, rl;
        int          lat;

        vt[0] = '{2'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 18};
        vt[1] = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vt[2] = '{2'd2, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 34};
        vt[3] = '{2'd2, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 2};
        vt[4] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vt[5] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 18};
        vt[6] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 18};
        vt[7] = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        vt[8] = '{2'd3, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 2};

        rst = 1'b1;
        f_flush = 0; f_in_valid = 0; f_out_ready = 0; f_op = 0; f_a = 0; f_b = 0;
        e_flush = 0; e_in_valid = 0; e_out_ready = 0; e_op = 0; e_a = 0; e_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(f_in_ready), 1);
        chk("rst_busy_valid", longint'({f_busy, f_out_valid}), 0);
        chk("rst_hilo", longint'({f_hi, f_lo}), 0);
        chk("rst_w8_ready", longint'(e_in_ready), 7);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run32(vt[i].op, vt[i].a, vt[i].b, h, l, lat);
            chk($sformatf("vec%0d_lat", i), longint'(lat), longint'(vt[i].lat));
            chk($sformatf("vec%0d_hi", i), longint'(h), longint'(vt[i].hi));
            chk($sformatf("vec%0d_lo", i), longint'(l), longint'(vt[i].lo));
            release32();
        end

        // Flush mid-divide with a competing request in the same cycle.
        f_op = 2'd3; f_a = 32'd100; f_b = 32'd7; f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush_pre_busy", longint'(f_busy), 1);
        f_flush = 1'b1; f_in_valid = 1'b1; f_op = 2'd0; f_a = 32'd3; f_b = 32'd4;
        @(posedge clk); #1;
        f_flush = 1'b0; f_in_valid = 1'b0;
        chk("flush_idle", longint'({f_busy, f_out_valid, f_in_ready}), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_quiet", longint'({f_busy, f_out_valid}), 0);
        run32(2'd3, 32'd100, 32'd7, h, l, lat);
        chk("after_flush_lat", longint'(lat), 34);
        chk("after_flush_hilo", longint'({h, l}), longint'({32'd2, 32'd14}));
        release32();

        // Backpressure: result must hold while out_ready stays low.
        run32(2'd0, 32'h12345678, 32'h10, h0, l0, lat);
        chk("bp_result", longint'({h0, l0}), longint'({32'h1, 32'h23456780}));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", c), longint'({f_hi, f_lo, f_out_valid, f_in_ready}),
                longint'({h0, l0, 1'b1, 1'b0}));
        end
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_out_ready = 1'b0;
        chk("bp_release", longint'({f_out_valid, f_in_ready}), 1);

        // Asynchronous reset in the middle of MUL_RUN.
        f_op = 2'd0; f_a = 32'hFFFFFFFF; f_b = 32'hFFFFFFFF; f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", longint'(f_busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ctl", longint'({f_busy, f_out_valid, f_in_ready}), 1);
        chk("async_rst_hilo", longint'({f_hi, f_lo}), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Random 32-bit ops against the reference model.
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            run32(rop, ra, rb, h, l, lat);
            refm(32, rop, longint'(ra), longint'(rb), rh, rl);
            chk($sformatf("r32_%0d_lat", i), longint'(lat), longint'(lat_exp(32, 2, rop, longint'(rb))));
            chk($sformatf("r32_%0d_hi", i), longint'(h), rh);
            chk($sformatf("r32_%0d_lo", i), longint'(l), rl);
            release32();
        end

        // 8-bit sweep over MUL_STEP 1/2/4: corners then random.
        run8(2'd3, 8'h80, 8'hFF);
        run8(2'd1, 8'h80, 8'h80);
        run8(2'd3, 8'hF9, 8'h00);
        run8(2'd0, 8'hFF, 8'hFF);
        for (int i = 0; i < 40; i++) begin
            run8(2'($urandom_range(0, 3)), 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the fixed-width, single-purpose MULT and DIV blocks with one shared iterative datapath.
- Configurable operand width and multiplier bits-per-cycle.
- Signed and unsigned modes.
- valid/ready handshakes on input and output, plus a flush (cancel) input.
- Produces {hi, lo} for the HI/LO write path.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.
MUL_STEP, 2, multiplier bits retired per cycle; must divide WIDTH (1, 2 or 4).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  abort current operation; drop any result (exception or branch kill).
in_valid  in  1  operation request.
in_ready  out  1  unit can accept a request (state IDLE).
op  in  2  operation: 0 MULU, 1 MUL, 2 DIVU, 3 DIV.
a  in  WIDTH  multiplicand or dividend.
b  in  WIDTH  multiplier or divisor.
out_valid  out  1  result available (state DONE).
out_ready  in  1  consumer accepts result.
hi  out  WIDTH  MUL: upper half of product. DIV: remainder.
lo  out  WIDTH  MUL: lower half of product. DIV: quotient.
busy  out  1  state other than IDLE.

Behaviour:
- States:
  - IDLE: default.
  - MUL_RUN: iterative multiply.
  - DIV_RUN: iterative divide.
  - FIX: sign correction.
  - DONE: result held for consumer.
- Reset (asynchronous, any state):
  - state=IDLE, counter=0, hi=lo=0.
  - out_valid=0, busy=0, in_ready=1.
- Accept: handshake fires on a rising edge where in_valid & in_ready & !flush.
  - Latch op.
  - Latch magnitudes of a and b: two's-complement negate if the mode is signed and the MSB is set.
  - Latch the quotient sign (a_msb ^ b_msb) and the remainder sign (a_msb), both signed modes only.
- MUL_RUN: counter starts at WIDTH/MUL_STEP.
  - Each cycle adds MUL_STEP partial products into a 2*WIDTH accumulator and shifts.
  - Enter FIX on the edge where the counter reaches 0.
- DIV_RUN: restoring radix-2, 1 quotient bit per cycle, counter starts at WIDTH.
  - Uses a WIDTH+1-bit partial remainder with compare/subtract.
  - Enter FIX when the counter reaches 0.
- Divide by zero (b==0, DIVU or DIV): go IDLE->FIX directly.
  - Result: lo = all ones; hi = a as given (raw, unsigned interpretation).
  - No sign correction is applied.
- FIX:
  - MUL signed: negate the 2*WIDTH product if the quotient-sign bit is set.
  - DIV signed: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Next state: DONE.
- Latency, counted from the accepting edge to the first cycle out_valid=1:
  - MUL: WIDTH/MUL_STEP+2 (18 at 32/2).
  - DIV: WIDTH+2 (34).
  - Divide by zero: 2.
- DONE:
  - hi/lo are stable while out_valid=1.
  - out_valid & out_ready on an edge -> IDLE.
  - Without out_ready, stay in DONE indefinitely.
  - in_ready=0 throughout DONE; there is no overlap between operations.
- flush: synchronous priority over everything except reset.
  - Any state -> IDLE on the next edge; out_valid=0 that cycle.
  - A request presented in the same cycle is not accepted.
  - hi/lo keep their last values; they are don't-care when out_valid=0.
- Most-negative operand: magnitude negation of 100..0 yields 100..0, which is treated as unsigned.
  - DIV of 100..0 by -1: lo = 100..0, hi = 0; no trap is raised.
- Illegal op codes cannot occur; the 2-bit op is fully decoded.
- Overflow checks are not performed; the ALU owns EX_OV.

Decomposition:
- Shared package (mycpu package): muldiv_op_t enum {MD_MULU, MD_MUL, MD_DIVU, MD_DIV} and muldiv_stat_t enum of the five states.
- The shared package also carries a muldiv_result_t struct {hi, lo}, which the execute stage consumes into write_hilo.
- Natural sub-module: execute_muldiv_step. It is combinational and holds one MUL_STEP multiply-accumulate step and one restoring-divide step. This keeps the FSM and counter in the top.

Test Plan:
- MUL a=0xFFFFFFFD (-3), b=5, WIDTH=32 -> out_valid exactly 18 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 34 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
- DIVU a=0x1234, b=0 -> out_valid after 2 cycles; lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIV, assert flush at cycle 10 with in_valid=1 -> IDLE next edge, no out_valid, new request not accepted. The next request afterwards completes correctly.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> hi/lo stable, in_ready=0. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- Parameter sweep: WIDTH=8, MUL_STEP in {1,2,4}, random a/b in all four ops against a reference model. Also check asynchronous reset asserted mid-MUL_RUN -> all outputs zero immediately.
